tmds_decoder_dvi: RTL

TMDS_DECODER_DVI -- requirements
Module: tmds_decoder_dvi

---
 rtl/tmds_decoder_dvi.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/tmds_decoder_dvi.sv
// TMDS decoder for one DVI channel: input word register, control-token
// detection and 8b data decode, plus a word-alignment state machine that
// drives bitslip requests to the deserializer until control tokens line up.
//
// state   | meaning
// --------+---------------------------------------------------------------
// SEARCH  | counting consecutive tokens; timeout forces a bitslip
// SLIP    | one-cycle bitslip pulse, slip counter advances
// WAIT    | deserializer settle time, incoming words ignored
// LOCKED  | aligned; data enable recovered; drop out if tokens stop
module tmds_decoder_dvi #(
  parameter int C_LOCK_TOKENS   = 64,
  parameter int C_SEARCH_CYCLES = 8192,
  parameter int C_SLIP_WAIT     = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_tmds,
  output logic       o_bitslip,
  output logic       o_aligned,
  output logic       o_de,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl,
  output logic [3:0] o_slip_cnt
);

  localparam int RUN_W = $clog2(C_LOCK_TOKENS) + 1;
  localparam int TO_W  = $clog2(C_SEARCH_CYCLES) + 1;
  localparam int WT_W  = $clog2(C_SLIP_WAIT) + 1;

  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(C_LOCK_TOKENS);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(C_SEARCH_CYCLES - 1);
  localparam logic [WT_W-1:0]  WT_LAST  = WT_W'(C_SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SLIP,
    ST_WAIT,
    ST_LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [WT_W-1:0]  wt_q, wt_d;
  logic [3:0]       slip_q, slip_d;

  logic [9:0] tmds_q;
  logic       tok_hit;
  logic [1:0] tok_val;
  logic [7:0] d_word;
  logic [7:0] x_word;
  logic [7:0] dec_word;

  logic       tok_q;
  logic       de_raw_q;
  logic [7:0] data_q;
  logic [1:0] ctrl_q;

  // Stage 1: capture the raw deserializer word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) tmds_q <= '0;
    else       tmds_q <= i_tmds;
  end

  // Control-token recognition on the registered word.
  always_comb begin
    tok_hit = 1'b1;
    tok_val = 2'b00;
    case (tmds_q)
      10'b1101010100: tok_val = 2'b00;
      10'b0010101011: tok_val = 2'b01;
      10'b0101010100: tok_val = 2'b10;
      10'b1010101011: tok_val = 2'b11;
      default:        tok_hit = 1'b0;
    endcase
  end

  // Data decode: undo the optional inversion, then the XOR/XNOR chain.
  always_comb begin
    d_word   = tmds_q[9] ? ~tmds_q[7:0] : tmds_q[7:0];
    x_word   = d_word ^ {d_word[6:0], 1'b0};
    dec_word = tmds_q[8] ? {x_word[7:1], d_word[0]} : {~x_word[7:1], d_word[0]};
  end

  // Stage 2: decoded word; control bits only update on tokens.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tok_q    <= 1'b0;
      de_raw_q <= 1'b0;
      data_q   <= '0;
      ctrl_q   <= '0;
    end else begin
      tok_q    <= tok_hit;
      de_raw_q <= ~tok_hit;
      data_q   <= tok_hit ? 8'h00 : dec_word;
      if (tok_hit) ctrl_q <= tok_val;
    end
  end

  // Alignment state and counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_SEARCH;
      run_q   <= '0;
      to_q    <= '0;
      wt_q    <= '0;
      slip_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      to_q    <= to_d;
      wt_q    <= wt_d;
      slip_q  <= slip_d;
    end
  end

  // Next-state and counter logic; counters saturate rather than wrap.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    to_d    = to_q;
    wt_d    = wt_q;
    slip_d  = slip_q;
    case (state_q)
      ST_SEARCH: begin
        if (tok_q) run_d = (run_q == '1) ? run_q : run_q + 1'b1;
        else       run_d = '0;
        to_d = (to_q == '1) ? to_q : to_q + 1'b1;
        // Lock is checked first so it wins a same-cycle timeout.
        if (run_q >= RUN_LOCK) begin
          state_d = ST_LOCKED;
          run_d   = '0;
          to_d    = '0;
        end else if (to_q >= TO_LAST) begin
          state_d = ST_SLIP;
          run_d   = '0;
          to_d    = '0;
        end
      end
      ST_SLIP: begin
        slip_d  = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
        wt_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wt_q >= WT_LAST) begin
          state_d = ST_SEARCH;
          run_d   = '0;
          to_d    = '0;
          wt_d    = '0;
        end else begin
          wt_d = (wt_q == '1) ? wt_q : wt_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (tok_q) begin
          to_d = '0;
        end else if (to_q >= TO_LAST) begin
          state_d = ST_SEARCH;
          to_d    = '0;
          run_d   = '0;
        end else begin
          to_d = (to_q == '1) ? to_q : to_q + 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Output gating: nothing leaves as pixel data unless aligned.
  always_comb begin
    o_bitslip  = (state_q == ST_SLIP);
    o_aligned  = (state_q == ST_LOCKED);
    o_de       = de_raw_q & o_aligned;
    o_data     = o_aligned ? data_q : 8'h00;
    o_ctrl     = ctrl_q;
    o_slip_cnt = slip_q;
  end

endmodule
